execute_stage_mc: RTL and testbench

Parametrised execute stage with an optional iterative multiplier. It replaces the fixed 18-bit single-cycle EX stage. It sits between the ID/EX and EX/MEM boundaries: it forwards operands, runs the ALU or multiplier, resolves branches, and owns the EX/MEM pipeline register. Multi-cycle operations stall the front end through `StallE`, and flush squashes the instruction in EX, including one in flight.

---
 rtl/exec_pkg.sv | 31 +++
 rtl/execute_stage_mc_seq_multiplier.sv | 117 +++++++++++
 rtl/execute_stage_mc.sv | 195 +++++++++++++++++++
 tb/tb_execute_stage_mc.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// ----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the execute stage: ALU operation codes, forwarding
// select codes and the state type of the iterative multiplier.
// ----------------------------------------------------------------------------
package exec_pkg;

   // ALU operation codes carried on ALUControlE
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_MUL = 4'd8;

   // Forwarding selects (code 2'b11 falls back to the register file)
   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_WB  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;

   // Iterative multiplier states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/execute_stage_mc_seq_multiplier.sv
// ----------------------------------------------------------------------------
// seq_multiplier
// Shift-add multiplier producing the low DATA_W bits of an unsigned product,
// one partial product per cycle. Owns the IDLE/BUSY/DONE sequencing and the
// step counter.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request a multiply (honoured only in IDLE)
//   abort      : cancel an operation in progress; return to IDLE
//   a, b       : operands, captured on the edge leaving IDLE
//   busy       : high while shift-add steps are running
//   done       : high for the single cycle the product is valid
//   product    : low DATA_W bits of a*b (valid while done)
// ----------------------------------------------------------------------------
module seq_multiplier
   import exec_pkg::*;
#(
   parameter int DATA_W = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int               CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mul_state_t        state;
   mul_state_t        state_next;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic; abort always wins over progress
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_next = BUSY;
            end else begin
               state_next = IDLE;
            end
         end
         BUSY: begin
            if (abort) begin
               state_next = IDLE;
            end else if (count == CNT_ONE) begin
               state_next = DONE;
            end else begin
               state_next = BUSY;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, step counter and shift-add accumulation
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= {CNT_W{1'b0}};
         acc    <= {DATA_W{1'b0}};
         mcand  <= {DATA_W{1'b0}};
         mplier <= {DATA_W{1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  mcand  <= a;
                  mplier <= b;
                  acc    <= {DATA_W{1'b0}};
                  count  <= CNT_LOAD;
               end
            end
            BUSY: begin
               if (abort) begin
                  count <= {CNT_W{1'b0}};
               end else begin
                  if (mplier[0]) begin
                     acc <= acc + mcand;
                  end
                  mcand  <= {mcand[DATA_W-2:0], 1'b0};
                  mplier <= {1'b0, mplier[DATA_W-1:1]};
                  count  <= count - CNT_ONE;
               end
            end
            default: begin
               count <= count;
            end
         endcase
      end
   end

   assign busy    = (state == BUSY);
   assign done    = (state == DONE);
   assign product = acc;

endmodule

// File: rtl/execute_stage_mc.sv
// ----------------------------------------------------------------------------
// execute_stage_mc
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM
// pipeline register. When compiled with EXEC_MUL_EN defined, op 8 runs on an
// iterative multiplier and holds the front end through StallE; otherwise op 8
// yields 0 in a single cycle and StallE is tied low.
//
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   RegWriteE/MemWriteE/ResultSrcE  : decoded controls of the EX instruction
//   BranchE                         : instruction is a branch-on-zero
//   FlushE                          : squash the EX instruction (and any multiply)
//   ALUControlE                     : operation code
//   RD1_E, RD2_E, Imm_Ext_E         : register operands and immediate
//   ResultW                         : write-back result for forwarding
//   RD_E, PCE, PCPlus4E, RGB_E      : destination, PC, PC+4, colour tag
//   ForwardA_E, ForwardB_E          : forwarding selects
//   ALUSrcE                         : use immediate as operand B
//   StallE                          : hold IF/ID/EX while a multiply runs
//   PCSrcE, PCTargetE               : branch taken and its target
//   *M outputs                      : EX/MEM pipeline register
// ----------------------------------------------------------------------------
module execute_stage_mc
   import exec_pkg::*;
#(
   parameter int DATA_W = 18,
   parameter int PC_W   = 9,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWriteE,
   input  logic              MemWriteE,
   input  logic              ResultSrcE,
   input  logic              BranchE,
   input  logic              FlushE,
   input  logic [3:0]        ALUControlE,
   input  logic [DATA_W-1:0] RD1_E,
   input  logic [DATA_W-1:0] RD2_E,
   input  logic [DATA_W-1:0] Imm_Ext_E,
   input  logic [DATA_W-1:0] ResultW,
   input  logic [REG_W-1:0]  RD_E,
   input  logic [PC_W-1:0]   PCE,
   input  logic [PC_W-1:0]   PCPlus4E,
   input  logic [1:0]        ForwardA_E,
   input  logic [1:0]        ForwardB_E,
   input  logic [1:0]        RGB_E,
   input  logic              ALUSrcE,
   output logic              StallE,
   output logic              PCSrcE,
   output logic [PC_W-1:0]   PCTargetE,
   output logic              RegWriteM,
   output logic              MemWriteM,
   output logic              ResultSrcM,
   output logic [REG_W-1:0]  RD_M,
   output logic [DATA_W-1:0] ALU_ResultM,
   output logic [DATA_W-1:0] WriteDataM,
   output logic [PC_W-1:0]   PCPlus4M,
   output logic [1:0]        RGB_M
);

   localparam int              SH_W     = $clog2(DATA_W);
   localparam logic [SH_W:0]   SH_LIMIT = (SH_W + 1)'(DATA_W);

   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] fwd_b;
   logic [DATA_W-1:0] src_b;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] result;
   logic [SH_W-1:0]   shamt;
   logic              zero;
   logic              bubble;

   // Operand A forwarding mux
   always_comb begin
      src_a = RD1_E;
      case (ForwardA_E)
         FWD_WB:  src_a = ResultW;
         FWD_MEM: src_a = ALU_ResultM;
         default: src_a = RD1_E;
      endcase
   end

   // Operand B forwarding mux
   always_comb begin
      fwd_b = RD2_E;
      case (ForwardB_E)
         FWD_WB:  fwd_b = ResultW;
         FWD_MEM: fwd_b = ALU_ResultM;
         default: fwd_b = RD2_E;
      endcase
   end

   assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
   assign shamt = src_b[SH_W-1:0];

   // Single-cycle ALU; shift amounts that reach the word width yield 0
   always_comb begin
      alu_res = {DATA_W{1'b0}};
      case (ALUControlE)
         ALU_ADD: alu_res = src_a + src_b;
         ALU_SUB: alu_res = src_a - src_b;
         ALU_AND: alu_res = src_a & src_b;
         ALU_OR:  alu_res = src_a | src_b;
         ALU_XOR: alu_res = src_a ^ src_b;
         ALU_SLL: begin
            if ({1'b0, shamt} >= SH_LIMIT) begin
               alu_res = {DATA_W{1'b0}};
            end else begin
               alu_res = src_a << shamt;
            end
         end
         ALU_SRL: begin
            if ({1'b0, shamt} >= SH_LIMIT) begin
               alu_res = {DATA_W{1'b0}};
            end else begin
               alu_res = src_a >> shamt;
            end
         end
         ALU_SLT: begin
            if ($signed(src_a) < $signed(src_b)) begin
               alu_res = {{(DATA_W-1){1'b0}}, 1'b1};
            end else begin
               alu_res = {DATA_W{1'b0}};
            end
         end
         default: alu_res = {DATA_W{1'b0}};
      endcase
   end

`ifdef EXEC_MUL_EN
   logic              mul_start;
   logic              mul_busy;
   logic              mul_done;
   logic              mul_idle;
   logic [DATA_W-1:0] mul_product;

   assign mul_start = (ALUControlE == ALU_MUL) && !FlushE;

   seq_multiplier #(
      .DATA_W (DATA_W)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .abort   (FlushE),
      .a       (src_a),
      .b       (src_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   assign mul_idle = !mul_busy && !mul_done;
   // The DONE cycle releases the stall so the product and front end advance together
   assign StallE   = (mul_idle && mul_start) || mul_busy;
   assign result   = mul_done ? mul_product : alu_res;
   assign zero     = (result == {DATA_W{1'b0}});
   assign PCSrcE   = BranchE && zero && !FlushE && mul_idle;
`else
   assign StallE   = 1'b0;
   assign result   = alu_res;
   assign zero     = (result == {DATA_W{1'b0}});
   assign PCSrcE   = BranchE && zero && !FlushE;
`endif

   assign PCTargetE = PCE + Imm_Ext_E[PC_W-1:0];

   // Stalled or flushed cycles hand the M stage a bubble (no writes)
   assign bubble = StallE || FlushE;

   // EX/MEM pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWriteM   <= 1'b0;
         MemWriteM   <= 1'b0;
         ResultSrcM  <= 1'b0;
         RD_M        <= {REG_W{1'b0}};
         ALU_ResultM <= {DATA_W{1'b0}};
         WriteDataM  <= {DATA_W{1'b0}};
         PCPlus4M    <= {PC_W{1'b0}};
         RGB_M       <= 2'b00;
      end else begin
         RegWriteM   <= RegWriteE && !bubble;
         MemWriteM   <= MemWriteE && !bubble;
         ResultSrcM  <= ResultSrcE;
         RD_M        <= RD_E;
         ALU_ResultM <= result;
         WriteDataM  <= fwd_b;
         PCPlus4M    <= PCPlus4E;
         RGB_M       <= RGB_E;
      end
   end

endmodule

// File: tb/tb_execute_stage_mc.sv
// ----------------------------------------------------------------------------
// tb_execute_stage_mc
// Scoreboard bench for execute_stage_mc. The driver applies one instruction
// per cycle on the falling edge, runs a behavioural model of the stage and
// queues the expected combinational outputs and the expected EX/MEM contents.
// Two monitors pop and compare independently. Works with and without
// EXEC_MUL_EN defined.
// ----------------------------------------------------------------------------
module tb_execute_stage_mc;

   localparam int DW = 18;
   localparam int PW = 9;
   localparam int RW = 5;
`ifdef EXEC_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          RegWriteE, MemWriteE, ResultSrcE, BranchE, FlushE, ALUSrcE;
   logic [3:0]    ALUControlE;
   logic [DW-1:0] RD1_E, RD2_E, Imm_Ext_E, ResultW;
   logic [RW-1:0] RD_E;
   logic [PW-1:0] PCE, PCPlus4E;
   logic [1:0]    ForwardA_E, ForwardB_E, RGB_E;
   logic          StallE, PCSrcE;
   logic [PW-1:0] PCTargetE;
   logic          RegWriteM, MemWriteM, ResultSrcM;
   logic [RW-1:0] RD_M;
   logic [DW-1:0] ALU_ResultM, WriteDataM;
   logic [PW-1:0] PCPlus4M;
   logic [1:0]    RGB_M;

   execute_stage_mc #(.DATA_W(DW), .PC_W(PW), .REG_W(RW)) dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
      .BranchE(BranchE), .FlushE(FlushE), .ALUControlE(ALUControlE),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .ResultW(ResultW),
      .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .RGB_E(RGB_E),
      .ALUSrcE(ALUSrcE),
      .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
      .PCPlus4M(PCPlus4M), .RGB_M(RGB_M)
   );

   typedef struct {
      bit            chk_data;
      logic          rw, mw, rs;
      logic [RW-1:0] rd;
      logic [DW-1:0] alu, wd;
      logic [PW-1:0] pc4;
      logic [1:0]    rgb;
   } m_exp_t;

   typedef struct {
      logic          stall, pcsrc;
      logic [PW-1:0] pct;
   } c_exp_t;

   m_exp_t m_q[$];
   c_exp_t c_q[$];
   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: the M register as the spec defines it, plus
   // the multiply progress as a count of remaining busy cycles.
   logic [DW-1:0] mdl_m_alu   = '0;
   bit            mdl_m_known = 1'b0;
   int            mdl_left    = 0;
   bit            mdl_done    = 1'b0;
   logic [DW-1:0] mdl_prod    = '0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint sgn(logic [DW-1:0] v);
      longint s = longint'(v);
      if (v[DW-1]) s = s - (longint'(1) << DW);
      return s;
   endfunction

   function automatic logic [DW-1:0] alu_ref(int op, logic [DW-1:0] a, logic [DW-1:0] b);
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint md = longint'(1) << DW;
      int     sh = int'(b) % 32;
      case (op)
         0: return DW'((ua + ub) % md);
         1: return DW'((ua - ub + md) % md);
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return (sh >= DW) ? '0 : DW'((ua << sh) % md);
         6: return (sh >= DW) ? '0 : DW'(ua >> sh);
         7: return (sgn(a) < sgn(b)) ? DW'(1) : DW'(0);
         default: return '0;
      endcase
   endfunction

   function automatic logic [DW-1:0] fwd_sel(logic [1:0] s, logic [DW-1:0] rf);
      case (s)
         2'd1:    return ResultW;
         2'd2:    return mdl_m_alu;
         default: return rf;
      endcase
   endfunction

   // Evaluate one cycle of the model on the currently applied inputs
   task automatic model_cycle();
      logic [DW-1:0] a, b, sb, res;
      c_exp_t c;
      m_exp_t m;
      bit bub;
      a   = fwd_sel(ForwardA_E, RD1_E);
      b   = fwd_sel(ForwardB_E, RD2_E);
      sb  = ALUSrcE ? Imm_Ext_E : b;
      c.pct   = PW'((int'(PCE) + int'(Imm_Ext_E)) % (1 << PW));
      c.pcsrc = 1'b0;
      res = '0;
      bub = 1'b1;
      if (mdl_left > 0) begin
         c.stall = 1'b1;
         if (FlushE) mdl_left = 0;
         else begin
            mdl_left--;
            if (mdl_left == 0) mdl_done = 1'b1;
         end
      end else if (mdl_done) begin
         c.stall  = 1'b0;
         res      = mdl_prod;
         bub      = FlushE;
         mdl_done = 1'b0;
      end else if (MUL_EN && ALUControlE == 4'd8 && !FlushE) begin
         c.stall  = 1'b1;
         mdl_prod = DW'((longint'(a) * longint'(sb)) % (longint'(1) << DW));
         mdl_left = DW;
      end else begin
         c.stall = 1'b0;
         res     = alu_ref(int'(ALUControlE), a, sb);
         bub     = FlushE;
         c.pcsrc = BranchE && (res == '0) && !FlushE;
      end
      m.chk_data = !bub;
      m.rw  = RegWriteE && !bub;
      m.mw  = MemWriteE && !bub;
      m.rs  = ResultSrcE;
      m.rd  = RD_E;
      m.alu = res;
      m.wd  = b;
      m.pc4 = PCPlus4E;
      m.rgb = RGB_E;
      if (rst) begin
         mdl_left = 0;
         mdl_done = 1'b0;
         m = '{1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 2'b00};
      end
      mdl_m_known = m.chk_data;
      mdl_m_alu   = m.alu;
      c_q.push_back(c);
      m_q.push_back(m);
   endtask

   task automatic tick();
      model_cycle();
      @(negedge clk);
   endtask

   task automatic clear_in();
      rst = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 1'b0;
      BranchE = 1'b0; FlushE = 1'b0; ALUSrcE = 1'b0; ALUControlE = 4'd0;
      RD1_E = '0; RD2_E = '0; Imm_Ext_E = '0; ResultW = '0; RD_E = '0;
      PCE = '0; PCPlus4E = '0; ForwardA_E = 2'd0; ForwardB_E = 2'd0; RGB_E = 2'd0;
   endtask

   function automatic logic [1:0] pick_fwd();
      logic [1:0] f = 2'($urandom_range(0, 3));
      if (f == 2'd2 && !mdl_m_known) f = 2'd0;
      return f;
   endfunction

   task automatic rand_data();
      RD1_E = DW'($urandom);
      RD2_E = DW'($urandom);
      if ($urandom_range(0, 3) == 0) RD2_E = RD1_E;
      ResultW    = DW'($urandom);
      Imm_Ext_E  = DW'($urandom);
      ForwardA_E = pick_fwd();
      ForwardB_E = pick_fwd();
   endtask

   task automatic rand_ctrl();
      ALUControlE = ($urandom_range(0, 9) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      RegWriteE   = 1'($urandom);
      MemWriteE   = 1'($urandom);
      ResultSrcE  = 1'($urandom);
      ALUSrcE     = 1'($urandom);
      BranchE     = (ALUControlE == 4'd8) ? 1'b0 : 1'($urandom);
      FlushE      = ($urandom_range(0, 9) == 0);
      RD_E        = RW'($urandom);
      PCE         = PW'($urandom);
      PCPlus4E    = PW'($urandom);
      RGB_E       = 2'($urandom);
   endtask

   // Keep ticking while the model says a multiply is in progress
   task automatic run_to_idle(int flush_at);
      int k = 0;
      while ((mdl_left > 0 || mdl_done) && k < 40) begin
         rand_data();
         FlushE = (k == flush_at);
         tick();
         k++;
      end
   endtask

   // Monitor: combinational outputs of the cycle just applied
   initial begin
      c_exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (c_q.size() > 0) begin
            e = c_q.pop_front();
            check("StallE", 32'(StallE), 32'(e.stall));
            check("PCSrcE", 32'(PCSrcE), 32'(e.pcsrc));
            check("PCTargetE", 32'(PCTargetE), 32'(e.pct));
         end
      end
   end

   // Monitor: EX/MEM register after each rising edge
   initial begin
      m_exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (m_q.size() > 0) begin
            e = m_q.pop_front();
            check("RegWriteM", 32'(RegWriteM), 32'(e.rw));
            check("MemWriteM", 32'(MemWriteM), 32'(e.mw));
            if (e.chk_data) begin
               check("ResultSrcM", 32'(ResultSrcM), 32'(e.rs));
               check("RD_M", 32'(RD_M), 32'(e.rd));
               check("ALU_ResultM", 32'(ALU_ResultM), 32'(e.alu));
               check("WriteDataM", 32'(WriteDataM), 32'(e.wd));
               check("PCPlus4M", 32'(PCPlus4M), 32'(e.pc4));
               check("RGB_M", 32'(RGB_M), 32'(e.rgb));
            end
         end
      end
   end

   // Driver
   initial begin
      clear_in();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b1; tick(); tick();

      // ADD with immediate: 5 + 7
      clear_in(); ALUControlE = 4'd0; RD1_E = 18'd5; Imm_Ext_E = 18'd7;
      ALUSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd3; tick();

      // Forwarding priority: seed M with 100, then SUB from MEM and from WB
      clear_in(); ALUControlE = 4'd0; RD1_E = 18'd100; ALUSrcE = 1'b1; RegWriteE = 1'b1; tick();
      clear_in(); ALUControlE = 4'd1; ForwardA_E = 2'd2; ResultW = 18'd50;
      RD1_E = 18'd9; RD2_E = 18'd40; RegWriteE = 1'b1; tick();
      clear_in(); ALUControlE = 4'd1; ForwardA_E = 2'd1; ResultW = 18'd50;
      RD1_E = 18'd9; RD2_E = 18'd40; RegWriteE = 1'b1; tick();
      // Select 11 falls back to the register file
      clear_in(); ALUControlE = 4'd0; ForwardA_E = 2'd3; ForwardB_E = 2'd3; ResultW = 18'd50;
      RD1_E = 18'd21; RD2_E = 18'd4; RegWriteE = 1'b1; tick();

      // Multiply 300 x 500
      clear_in(); ALUControlE = 4'd8; RD1_E = 18'd300; RD2_E = 18'd500;
      RegWriteE = 1'b1; RD_E = 5'd7; tick();
      run_to_idle(-1);

      // Flush on the fifth busy cycle, then idle cycles
      clear_in(); ALUControlE = 4'd8; RD1_E = 18'd123; RD2_E = 18'd456; RegWriteE = 1'b1; tick();
      run_to_idle(4);
      clear_in(); ALUControlE = 4'd9; tick(); tick();

      // Branch with PC wrap, then the same branch flushed
      clear_in(); ALUControlE = 4'd1; RD1_E = 18'd3; RD2_E = 18'd3; BranchE = 1'b1;
      PCE = 9'h1F0; Imm_Ext_E = 18'h20; tick();
      clear_in(); ALUControlE = 4'd1; RD1_E = 18'd3; RD2_E = 18'd3; BranchE = 1'b1;
      PCE = 9'h1F0; Imm_Ext_E = 18'h20; FlushE = 1'b1; tick();

      // Shift boundaries: amount 17 and 18
      clear_in(); ALUControlE = 4'd5; RD1_E = 18'd1; Imm_Ext_E = 18'd17; ALUSrcE = 1'b1; RegWriteE = 1'b1; tick();
      clear_in(); ALUControlE = 4'd5; RD1_E = 18'd1; Imm_Ext_E = 18'd18; ALUSrcE = 1'b1; RegWriteE = 1'b1; tick();
      clear_in(); ALUControlE = 4'd6; RD1_E = 18'h3FFFF; Imm_Ext_E = 18'd18; ALUSrcE = 1'b1; RegWriteE = 1'b1; tick();

      // Reset mid-multiply, then 1000 x 1000 completes normally
      clear_in(); ALUControlE = 4'd8; RD1_E = 18'd77; RD2_E = 18'd88; RegWriteE = 1'b1; tick();
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b1; tick();
      clear_in(); ALUControlE = 4'd8; RD1_E = 18'd1000; RD2_E = 18'd1000; RegWriteE = 1'b1; tick();
      run_to_idle(-1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         clear_in();
         rand_data();
         rand_ctrl();
         rst = ($urandom_range(0, 199) == 0);
         tick();
         if (mdl_left > 0) begin
            rst = 1'b0;
            run_to_idle(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1);
         end
      end

      clear_in();
      repeat (2) @(negedge clk);
      check("queues_drained", 32'(m_q.size() + c_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
